// File: rtl/ysyx_22040088_lsu_if.sv
// Data-memory bus between the LSU (master) and the data memory (slave).
// Request phase: mem_req held with stable fields until mem_gnt.
// Response phase: a single mem_rvalid beat carries read data or the write ack.
interface ysyx_22040088_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: one non-pipelined access on a 64-bit data bus.
// Accepts a decoded memory op, checks mask/alignment, steers store data and
// strobes into byte lanes, and extends the returned load lane for writeback.
// All outputs except in_ready are registered; their next values are derived
// from next_state so they line up with the state they belong to.
module ysyx_22040088_lsu (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       mem_ena,
  input  logic                       mem_wen,
  input  logic [3:0]                 mem_mask,
  input  logic [2:0]                 sel_rfres,
  input  logic [63:0]                addr,
  input  logic [63:0]                wdata,
  output logic                       out_valid,
  output logic [63:0]                out_rdata,
  output logic                       out_err,
  ysyx_22040088_lsu_if.master        bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // Fields of the accepted op needed when the response comes back.
  typedef struct packed {
    logic       wen;
    logic [3:0] mask;
    logic       sext;
    logic [2:0] off;
  } req_t;

  state_t      state, next_state;
  req_t        req_q;

  logic        accept;
  logic        align_ok;
  logic        acc_err;
  logic [7:0]  size_strb;
  logic [63:0] lane_data;
  logic [63:0] load_ext;

  logic        mem_req_d, mem_we_d, out_valid_d, out_err_d;
  logic [7:0]  mem_wstrb_d;
  logic [63:0] mem_addr_d, mem_wdata_d, out_rdata_d;

  // Only the sign-extend bit changes the result; zero-extend is the fallback.
  logic        unused_sel;
  assign unused_sel = sel_rfres[0] ^ sel_rfres[2];

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid & mem_ena & in_ready;

  // Size decode: alignment test and the unshifted strobe pattern per size.
  always_comb begin
    align_ok  = 1'b0;
    size_strb = 8'h00;
    case (mem_mask)
      4'b0001: begin align_ok = (addr[2:0] == 3'd0); size_strb = 8'hFF; end
      4'b0010: begin align_ok = (addr[1:0] == 2'd0); size_strb = 8'h0F; end
      4'b0100: begin align_ok = ~addr[0];            size_strb = 8'h03; end
      4'b1000: begin align_ok = 1'b1;                size_strb = 8'h01; end
      default: begin align_ok = 1'b0;                size_strb = 8'h00; end
    endcase
    acc_err = ~$onehot(mem_mask) | ~align_ok;
  end

  // Load path: bring the addressed lane down to bit 0, then extend by size.
  always_comb begin
    lane_data = bus.mem_rdata >> {req_q.off, 3'b000};
    load_ext  = lane_data;
    case (req_q.mask)
      4'b0010: load_ext = {{32{req_q.sext & lane_data[31]}}, lane_data[31:0]};
      4'b0100: load_ext = {{48{req_q.sext & lane_data[15]}}, lane_data[15:0]};
      4'b1000: load_ext = {{56{req_q.sext & lane_data[7]}},  lane_data[7:0]};
      default: load_ext = lane_data;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; rvalid outside WAIT is deliberately ignored.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = acc_err ? S_DONE : S_REQ;
      S_REQ:   if (bus.mem_gnt) next_state = S_WAIT;
      S_WAIT:  if (bus.mem_rvalid) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered bus and completion outputs.
  always_comb begin
    mem_req_d   = (next_state == S_REQ);
    out_valid_d = (next_state == S_DONE);
    out_err_d   = (state == S_IDLE) & (next_state == S_DONE);
    out_rdata_d = 64'd0;
    if ((state == S_WAIT) && (next_state == S_DONE) && !req_q.wen)
      out_rdata_d = load_ext;
    mem_we_d    = bus.mem_we;
    mem_addr_d  = bus.mem_addr;
    mem_wdata_d = bus.mem_wdata;
    mem_wstrb_d = bus.mem_wstrb;
    if (accept && !acc_err) begin
      mem_we_d    = mem_wen;
      mem_addr_d  = {addr[63:3], 3'b000};
      mem_wdata_d = wdata << {addr[2:0], 3'b000};
      mem_wstrb_d = mem_wen ? (size_strb << addr[2:0]) : 8'h00;
    end
  end

  // Output registers; bus fields only change on acceptance so they stay stable in REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_wstrb <= 8'h00;
      bus.mem_addr  <= 64'd0;
      bus.mem_wdata <= 64'd0;
      out_valid     <= 1'b0;
      out_err       <= 1'b0;
      out_rdata     <= 64'd0;
    end else begin
      bus.mem_req   <= mem_req_d;
      bus.mem_we    <= mem_we_d;
      bus.mem_wstrb <= mem_wstrb_d;
      bus.mem_addr  <= mem_addr_d;
      bus.mem_wdata <= mem_wdata_d;
      out_valid     <= out_valid_d;
      out_err       <= out_err_d;
      out_rdata     <= out_rdata_d;
    end
  end

  // Capture what the response phase needs from the accepted op.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.wen  <= mem_wen;
      req_q.mask <= mem_mask;
      req_q.sext <= sel_rfres[1];
      req_q.off  <= addr[2:0];
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Scoreboard bench for the LSU: a driver issues ops and pushes the expected
// completion and bus request, a memory responder grants/answers with
// programmable delays and checks the request, and a monitor checks completions.
module tb_ysyx_22040088_lsu;
  logic        clk, rst;
  logic        in_valid, in_ready, mem_ena, mem_wen;
  logic [3:0]  mem_mask;
  logic [2:0]  sel_rfres;
  logic [63:0] addr, wdata;
  logic        out_valid, out_err;
  logic [63:0] out_rdata;

  ysyx_22040088_lsu_if bus();

  ysyx_22040088_lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_mask(mem_mask),
    .sel_rfres(sel_rfres), .addr(addr), .wdata(wdata),
    .out_valid(out_valid), .out_rdata(out_rdata), .out_err(out_err),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [63:0] rdata; int acc; int lat; } exp_t;
  typedef struct { logic [63:0] addr; logic we; logic [7:0] wstrb; logic [63:0] wdata; } bus_t;
  exp_t exp_q[$];
  bus_t bus_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Responder controls; manual values take over when resp_en is low.
  logic        resp_en = 1'b1;
  int          gnt_dly = 0, rv_dly = 0;
  logic [63:0] rd_data = 64'd0;
  logic        r_gnt = 1'b0, r_rv = 1'b0;
  logic [63:0] r_rdata = 64'd0;
  logic        man_gnt = 1'b0, man_rv = 1'b0;
  logic [63:0] man_rdata = 64'd0;
  assign bus.mem_gnt    = resp_en ? r_gnt   : man_gnt;
  assign bus.mem_rvalid = resp_en ? r_rv    : man_rv;
  assign bus.mem_rdata  = resp_en ? r_rdata : man_rdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  // Reference: size from mask, lane offset from address, plain shifts/masks.
  function automatic void ref_model(input logic [63:0] a, input logic [63:0] wd,
      input logic [63:0] rd, input logic wen, input logic [3:0] m, input logic [2:0] sel,
      output logic err, output logic [63:0] res, output logic [7:0] strb,
      output logic [63:0] bwd);
    int n, off;
    logic [63:0] lm, s16;
    n   = (m == 4'b0001) ? 8 : (m == 4'b0010) ? 4 : (m == 4'b0100) ? 2 : (m == 4'b1000) ? 1 : 0;
    off = int'(a[2:0]);
    err = (n == 0) || ((a % 64'(n)) != 64'd0);
    s16 = ((64'd1 << n) - 64'd1) << off;
    strb = wen ? s16[7:0] : 8'h00;
    bwd  = wd << (8 * off);
    res  = 64'd0;
    if (!err && !wen) begin
      res = rd >> (8 * off);
      if (n < 8) begin
        lm  = (64'd1 << (8 * n)) - 64'd1;
        res = res & lm;
        if (sel[1] && res[8 * n - 1]) res = res | ~lm;
      end
    end
  endfunction

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (in_ready) return;
      @(negedge clk);
    end
    chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  // Issue one op at a negedge where in_ready is high, then wait for idle.
  task automatic issue(input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
      input logic wen, input logic [3:0] m, input logic [2:0] sel, input int gd, input int rvd);
    exp_t e; bus_t b; logic err; logic [63:0] res, bwd; logic [7:0] strb;
    ref_model(a, wd, rd, wen, m, sel, err, res, strb, bwd);
    e.err = err; e.rdata = res; e.acc = cyc; e.lat = err ? 1 : 3 + gd + rvd;
    exp_q.push_back(e);
    if (!err) begin
      b.addr = {a[63:3], 3'b000}; b.we = wen; b.wstrb = strb; b.wdata = bwd;
      bus_q.push_back(b);
    end
    gnt_dly = gd; rv_dly = rvd; rd_data = rd;
    in_valid = 1'b1; mem_ena = 1'b1; mem_wen = wen; mem_mask = m;
    sel_rfres = sel; addr = a; wdata = wd;
    @(negedge clk);
    in_valid = 1'b0; mem_ena = 1'b0; addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    wait_idle();
  endtask

  // Memory responder: checks each request, then grant and response after delays.
  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      if (resp_en && bus.mem_req) begin
        for (int i = 0; i < gnt_dly; i++) begin
          @(negedge clk);
          chk("req_held", {63'd0, bus.mem_req}, 64'd1);
        end
        if (bus_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_mem_req: got mem_req=1 addr %h required no request", bus.mem_addr);
        end else begin
          b = bus_q.pop_front();
          chk("mem_addr", bus.mem_addr, b.addr);
          chk("mem_we", {63'd0, bus.mem_we}, {63'd0, b.we});
          chk("mem_wstrb", {56'd0, bus.mem_wstrb}, {56'd0, b.wstrb});
          if (b.we) chk("mem_wdata", bus.mem_wdata, b.wdata);
        end
        r_gnt = 1'b1;
        @(negedge clk);
        r_gnt = 1'b0;
        chk("req_drop", {63'd0, bus.mem_req}, 64'd0);
        for (int i = 0; i < rv_dly; i++) @(negedge clk);
        r_rv = 1'b1; r_rdata = rd_data;
        @(negedge clk);
        r_rv = 1'b0; r_rdata = {$urandom, $urandom};
      end
    end
  end

  // Completion monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid=1 rdata %h required no completion", out_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("out_rdata", out_rdata, e.rdata);
          chk("out_err", {63'd0, out_err}, {63'd0, e.err});
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
    end
  end

  initial begin
    #500000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: got no finish required finish before time limit");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m; logic [63:0] a; logic w; logic [2:0] s;
    rst = 1'b1; in_valid = 1'b0; mem_ena = 1'b0; mem_wen = 1'b0; mem_mask = 4'd0;
    sel_rfres = 3'd0; addr = 64'd0; wdata = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    chk("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    chk("rst_mem_wstrb", {56'd0, bus.mem_wstrb}, 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    chk("rst_out_rdata", out_rdata, 64'd0);

    // Directed cases from the test plan.
    issue(64'h80000010, 64'd0, 64'h1122334455667788, 1'b0, 4'b0001, 3'b010, 0, 0);
    issue(64'h80000004, 64'd0, 64'h8000000000000000, 1'b0, 4'b0010, 3'b010, 0, 0);
    issue(64'h80000004, 64'd0, 64'h8000000000000000, 1'b0, 4'b0010, 3'b100, 0, 0);
    issue(64'h80000005, 64'd0, 64'h0000AB0000000000, 1'b0, 4'b1000, 3'b100, 0, 0);
    issue(64'h80000005, 64'd0, 64'h0000AB0000000000, 1'b0, 4'b1000, 3'b010, 0, 0);
    issue(64'h80000006, 64'h1234, 64'hDEADBEEFDEADBEEF, 1'b1, 4'b0100, 3'b001, 0, 0);
    issue(64'h80000006, 64'd0, 64'd0, 1'b0, 4'b0010, 3'b010, 0, 0);
    issue(64'h80000000, 64'd5, 64'd0, 1'b1, 4'b0000, 3'b001, 0, 0);
    issue(64'h80000018, 64'd0, 64'h0123456789ABCDEF, 1'b0, 4'b0001, 3'b010, 3, 0);
    issue(64'h80000022, 64'd0, 64'h00000000FFFF0000, 1'b0, 4'b0100, 3'b010, 1, 2);

    // Randomized ops: mostly legal and aligned, some illegal masks / misaligned.
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 9))
        0: m = 4'b0000;
        1: m = 4'b0110;
        default: m = 4'b0001 << $urandom_range(0, 3);
      endcase
      a = {32'h0, 32'h80000000 | 32'($urandom)};
      if ($urandom_range(0, 3) != 0) begin
        case (m)
          4'b0001: a[2:0] = 3'd0;
          4'b0010: a[1:0] = 2'd0;
          4'b0100: a[0]   = 1'b0;
          default: ;
        endcase
      end
      w = 1'($urandom_range(0, 1));
      s = w ? 3'b001 : ($urandom_range(0, 1) != 0 ? 3'b010 : 3'b100);
      issue(a, {$urandom, $urandom}, {$urandom, $urandom}, w, m, s,
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Non-memory op is ignored.
    in_valid = 1'b1; mem_ena = 1'b0; addr = 64'h80000008;
    @(negedge clk);
    in_valid = 1'b0;
    chk("non_mem_ready", {63'd0, in_ready}, 64'd1);
    chk("non_mem_req", {63'd0, bus.mem_req}, 64'd0);

    // Stray response in IDLE must not complete anything.
    resp_en = 1'b0;
    man_rv = 1'b1; man_rdata = 64'h5555;
    @(negedge clk);
    man_rv = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_ready", {63'd0, in_ready}, 64'd1);

    // Reset while waiting for the response; the late response is ignored.
    in_valid = 1'b1; mem_ena = 1'b1; mem_wen = 1'b0; mem_mask = 4'b0001;
    sel_rfres = 3'b010; addr = 64'h80000040;
    @(negedge clk);
    in_valid = 1'b0; mem_ena = 1'b0;
    chk("abort_req_up", {63'd0, bus.mem_req}, 64'd1);
    man_gnt = 1'b1;
    @(negedge clk);
    man_gnt = 1'b0;
    chk("abort_wait_req", {63'd0, bus.mem_req}, 64'd0);
    chk("abort_wait_busy", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_mem_req", {63'd0, bus.mem_req}, 64'd0);
    man_rv = 1'b1; man_rdata = 64'hCAFE;
    @(negedge clk);
    man_rv = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle", {63'd0, in_ready}, 64'd1);
    resp_en = 1'b1;

    // Back to normal operation after the abort.
    issue(64'h80000030, 64'hA5, 64'd0, 1'b1, 4'b1000, 3'b001, 0, 1);

    repeat (5) @(negedge clk);
    chk("sb_drain_out", 64'(exp_q.size()), 64'd0);
    chk("sb_drain_bus", 64'(bus_q.size()), 64'd0);
    summary();
    $finish;
  end
endmodule
